// File: rtl/calculator_pkg.sv
// Shared widths for the calculator datapath.
package calculator_pkg;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
endpackage

// File: rtl/operand_unpacker.sv
// Splits 64-bit memory words into two 32-bit ALU operands, low half first; first operand 1 cycle after word accept.
// Backpressure: holds operand/holding register while op_ready_i=0; takes a new word only when idle or draining the upper half.
module operand_unpacker
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MEM_WORD_SIZE-1:0] word_i,
  input  logic                     word_valid_i,
  output logic                     word_ready_o,
  output logic [DATA_W-1:0]        op_o,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic                     loc_o,
  output logic [7:0]               word_cnt_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                   state_q, state_d;
  logic [MEM_WORD_SIZE-1:0] held_q, held_d;
  logic [DATA_W-1:0]        op_q, op_d;
  logic                     loc_q, loc_d;
  logic                     vld_q, vld_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     word_hs;
  logic                     op_hs;

  // Ready never looks at word_valid_i, so upstream can't form a combinational loop through us.
  assign word_ready_o = (state_q == IDLE) || ((state_q == HIGH) && op_ready_i);
  assign word_hs      = word_valid_i && word_ready_o;
  assign op_hs        = vld_q && op_ready_i;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    op_d    = op_q;
    loc_d   = loc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (word_hs) begin
          held_d  = word_i;
          state_d = LOW;
          op_d    = word_i[DATA_W-1:0];
          loc_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      LOW: begin
        if (op_hs) begin
          state_d = HIGH;
          op_d    = held_q[MEM_WORD_SIZE-1:DATA_W];
          loc_d   = 1'b1;
        end
      end
      HIGH: begin
        if (op_hs) begin
          cnt_d = cnt_q + 8'd1;
          // A word taken alongside the upper-half handshake replaces the held one with no bubble.
          if (word_hs) begin
            held_d  = word_i;
            state_d = LOW;
            op_d    = word_i[DATA_W-1:0];
            loc_d   = 1'b0;
          end else begin
            state_d = IDLE;
            op_d    = '0;
            loc_d   = 1'b0;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = '0;
        loc_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      held_q  <= '0;
      op_q    <= '0;
      loc_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      op_q    <= op_d;
      loc_q   <= loc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_o       = op_q;
  assign loc_o      = loc_q;
  assign op_valid_o = vld_q;
  assign word_cnt_o = cnt_q;

endmodule
